// File: rtl/burst_ram_model.sv
// Burst RAM behind the I/D cache pair: models a DDR-style controller with a calibration
// period, a fixed read latency and multi-beat masked bursts.
module burst_ram_model #(
    parameter int DEPTH_BITWIDTH           = 4,
    parameter int DATA_BITWIDTH            = 64,
    parameter int BURST_DATA_COUNT         = 4,
    parameter int CYCLES_BEFORE_DATA_VALID = 3,
    parameter int CYCLES_BEFORE_INITIATED  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd,
    input  logic                         cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]    addr,
    input  logic [DATA_BITWIDTH-1:0]     wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
    output logic [DATA_BITWIDTH-1:0]     rd_data,
    output logic                         rd_data_valid,
    output logic                         busy
);

    localparam int DEPTH  = 2 ** DEPTH_BITWIDTH;
    localparam int BYTES  = DATA_BITWIDTH / 8;
    localparam int BEAT_W = $clog2(BURST_DATA_COUNT + 1);
    localparam int WAIT_W = $clog2(CYCLES_BEFORE_DATA_VALID + 1);
    localparam int INIT_W = (CYCLES_BEFORE_INITIATED < 1) ? 1 : $clog2(CYCLES_BEFORE_INITIATED + 1);
    localparam bit INIT_SKIP = (CYCLES_BEFORE_INITIATED == 0);

    localparam logic [BEAT_W-1:0] BEAT_ALL  = BEAT_W'(BURST_DATA_COUNT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_DATA_COUNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CYCLES_BEFORE_DATA_VALID - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_SKIP ? 0 : CYCLES_BEFORE_INITIATED - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_WAIT,
        S_RD_DATA,
        S_WR
    } state_t;

    state_t                      state;
    logic [DATA_BITWIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_BITWIDTH-1:0]   addr_reg;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [WAIT_W-1:0]           wait_cnt;
    logic [INIT_W-1:0]           init_cnt;
    logic                        mem_we;
    logic [DEPTH_BITWIDTH-1:0]   mem_waddr;

    // Beat 0 of a write lands on the accept edge straight from the bus; later beats use addr_reg.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg;
        if (state == S_IDLE && cmd_en && !cmd) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
        end else if (state == S_WR) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!data_mask[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read beats are fetched one edge ahead so rd_data is registered when valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT_SKIP ? S_IDLE : S_INIT;
            busy          <= !INIT_SKIP;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            addr_reg      <= '0;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            init_cnt      <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_en) begin
                        busy     <= 1'b1;
                        addr_reg <= addr + DEPTH_BITWIDTH'(1);
                        beat_cnt <= BEAT_W'(1);
                        if (!cmd) begin
                            state <= S_WR;
                        end else if (CYCLES_BEFORE_DATA_VALID == 1) begin
                            rd_data       <= mem[addr];
                            rd_data_valid <= 1'b1;
                            state         <= S_RD_DATA;
                        end else begin
                            addr_reg <= addr;
                            wait_cnt <= WAIT_W'(1);
                            state    <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        rd_data       <= mem[addr_reg];
                        rd_data_valid <= 1'b1;
                        addr_reg      <= addr_reg + DEPTH_BITWIDTH'(1);
                        beat_cnt      <= BEAT_W'(1);
                        state         <= S_RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_RD_DATA: begin
                    if (beat_cnt == BEAT_ALL) begin
                        rd_data_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        rd_data  <= mem[addr_reg];
                        addr_reg <= addr_reg + DEPTH_BITWIDTH'(1);
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                S_WR: begin
                    addr_reg <= addr_reg + DEPTH_BITWIDTH'(1);
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (beat_cnt == BEAT_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_model.sv
// Bench for burst_ram_model: directed and random bursts checked against a word-array
// model with cycle-exact latency expectations.
module tb_burst_ram_model;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int C  = 10;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd;
    logic          cmd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    data_mask;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          busy;

    logic [DW-1:0] mem_model [DEPTH];
    logic [DW-1:0] last_rd;
    int            n_compared;
    int            n_mismatch;

    burst_ram_model #(
        .DEPTH_BITWIDTH(AW),
        .DATA_BITWIDTH(DW),
        .BURST_DATA_COUNT(N),
        .CYCLES_BEFORE_DATA_VALID(L),
        .CYCLES_BEFORE_INITIATED(C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .cmd_en(cmd_en),
        .addr(addr),
        .wr_data(wr_data),
        .data_mask(data_mask),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_write(input int a, input logic [DW-1:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++) begin
            if (!m[b]) mem_model[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Reset, then walk the calibration window with cmd_en optionally held high.
    task automatic do_reset(input logic hold_cmd);
        rst_n  = 1'b0;
        cmd_en = hold_cmd;
        cmd    = 1'b1;
        addr   = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_valid", 64'(rd_data_valid), 64'(0));
        check("rst_data", rd_data, '0);
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= C; c++) begin
            if (c > 1) @(negedge clk);
            check("init_busy", 64'(busy), 64'(1));
            check("init_valid", 64'(rd_data_valid), 64'(0));
        end
        @(negedge clk);
        check("init_done_busy", 64'(busy), 64'(0));
        cmd_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [4*DW-1:0] beats, input logic [31:0] masks);
        check("wr_idle", 64'(busy), 64'(0));
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("wr_busy", 64'(busy), 64'(1));
                check("wr_valid", 64'(rd_data_valid), 64'(0));
                check("wr_hold", rd_data, last_rd);
            end
            cmd_en    = (i == 0);
            cmd       = 1'b0;
            addr      = a;
            wr_data   = beats[i*DW +: DW];
            data_mask = masks[i*8 +: 8];
            model_write(int'(a) + i, beats[i*DW +: DW], masks[i*8 +: 8]);
        end
        @(negedge clk);
        check("wr_done_busy", 64'(busy), 64'(0));
    endtask

    // pulse_k: cycle after accept with a stray write strobe; abort_k: return early at that cycle.
    task automatic do_read(input logic [AW-1:0] a, input int pulse_k, input int abort_k);
        logic [DW-1:0] beats [N];
        logic [DW-1:0] exp_data;
        for (int i = 0; i < N; i++) beats[i] = mem_model[(int'(a) + i) % DEPTH];
        check("rd_idle", 64'(busy), 64'(0));
        cmd_en = 1'b1;
        cmd    = 1'b1;
        addr   = a;
        for (int k = 1; k <= L + N; k++) begin
            @(negedge clk);
            exp_data = (k < L) ? last_rd : beats[(k - L < N) ? k - L : N - 1];
            check("rd_valid", 64'(rd_data_valid), 64'((k >= L && k < L + N) ? 1 : 0));
            check("rd_data", rd_data, exp_data);
            check("rd_busy", 64'(busy), 64'((k < L + N) ? 1 : 0));
            last_rd   = exp_data;
            cmd_en    = (k == pulse_k);
            cmd       = 1'b0;
            addr      = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = rand_word();
            data_mask = 8'h00;
            if (k == abort_k) return;
        end
    endtask

    logic [4*DW-1:0] beats_v;
    logic [31:0]     masks_v;
    logic [AW-1:0]   a_v;

    initial begin
        n_compared = 0;
        n_mismatch = 0;
        rst_n      = 1'b0;
        cmd        = 1'b1;
        cmd_en     = 1'b0;
        addr       = '0;
        wr_data    = '0;
        data_mask  = '0;
        last_rd    = '0;
        @(negedge clk);

        // Calibration window with cmd_en held from release.
        do_reset(1'b1);

        // Give every word a defined value.
        for (int a = 0; a < DEPTH; a += N) begin
            for (int i = 0; i < N; i++) beats_v[i*DW +: DW] = rand_word();
            do_write(AW'(a), beats_v, 32'h0);
        end

        // Basic write/read at address 4.
        do_write(4'd4, {64'h4444444444444444, 64'h3333333333333333,
                        64'h2222222222222222, 64'h1111111111111111}, 32'h0);
        do_read(4'd4, 0, 0);

        // Wrapping burst at the top address.
        for (int i = 0; i < N; i++) beats_v[i*DW +: DW] = rand_word();
        do_write(4'd15, beats_v, 32'h0);
        do_read(4'd15, 0, 0);
        do_read(4'd0, 0, 0);

        // Byte mask on beat 1 only; other beats fully masked.
        do_write(4'd0, {4{64'hAAAAAAAAAAAAAAAA}}, 32'h0);
        do_write(4'd0, {4{64'h5555555555555555}}, 32'hFFFF_F0FF);
        do_read(4'd0, 0, 0);

        // Stray write strobe while busy must be ignored.
        a_v = AW'($urandom_range(0, DEPTH - 1));
        do_read(a_v, 2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rd_valid", 64'(rd_data_valid), 64'(0));
            check("post_rd_busy", 64'(busy), 64'(0));
        end
        do_read(a_v, 0, 0);
        do_read(AW'(int'(a_v) + 2), 0, 0);

        // Reset after two beats of a read.
        a_v = AW'($urandom_range(0, DEPTH - 1));
        do_read(a_v, 0, L + 1);
        do_reset(1'b0);
        do_read(a_v, 0, 0);

        // Random masked writes followed by reads, some back to back.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) beats_v[i*DW +: DW] = rand_word();
            masks_v = (r % 2 == 0) ? $urandom() : 32'h0;
            a_v     = AW'($urandom_range(0, DEPTH - 1));
            do_write(a_v, beats_v, masks_v);
            do_read(a_v, 0, 0);
            do_read(AW'($urandom_range(0, DEPTH - 1)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
